// File: rtl/mem_pkg.sv
// Shared definitions for the memory access arbiter.
//  - Size encodings, which match the core's existing memory control unit.
//  - FSM state enum.
//  - access_bad(): flags an illegal size or a misaligned data access.
//  - lane_extract(): selects the addressed lane of a read word and extends it.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_ILL  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Misaligned halfword/word or the reserved size code: the access is
  // rejected without touching the memory bus.
  function automatic logic access_bad(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Pick the addressed byte/halfword out of the raw word and zero- or
  // sign-extend it; words pass through unchanged.
  function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for the memory port (purely combinational).
//  Write side: wr_size_i/wr_addr_lo_i/wr_data_i -> be_o (byte enables) and
//              wr_data_o (store data replicated across all lanes).
//  Read side:  rd_size_i/rd_addr_lo_i/rd_signed_i/rd_data_i -> rd_data_o
//              (lane-selected, extended load data).
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [1:0]  wr_size_i,
  input  logic [1:0]  wr_addr_lo_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wr_data_o,
  input  logic [1:0]  rd_size_i,
  input  logic [1:0]  rd_addr_lo_i,
  input  logic        rd_signed_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  always_comb begin
    be_o      = 4'b1111;
    wr_data_o = wr_data_i;
    case (wr_size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << wr_addr_lo_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      SZ_HALF: begin
        be_o      = wr_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      default: begin
        be_o      = 4'b1111;
        wr_data_o = wr_data_i;
      end
    endcase
  end

  assign rd_data_o = lane_extract(rd_data_i, rd_addr_lo_i, rd_size_i, rd_signed_i);

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the external memory port between instruction fetch and load/store.
//  Fetch side : if_req/if_addr in, if_ack/if_rdata/if_err out.
//  Data side  : d_req/d_we/d_size/d_signed/d_addr/d_wdata in,
//               d_ack/d_rdata/d_err out.
//  Memory bus : mem_req/mem_we/mem_addr/mem_be/mem_wdata out,
//               mem_ack/mem_rdata in.
//  Debug      : dbg_state shows the FSM state (state_e encoding).
//
// Handshake: a requester raises req with stable fields and holds it until
// its ack, a single-cycle pulse carrying rdata/err. On the memory side
// mem_req and all mem_* fields stay stable from grant until mem_ack, which
// completes the access in the cycle it is seen; the ack to the requester
// follows one cycle later from the RESP state.
module mem_access_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [7:0]  to_cnt_q;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        signed_q;

  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic        grant_d, grant_if, d_bad;
  logic [3:0]  wr_be;
  logic [31:0] wr_rep, rd_ext;

  // Fetch word alignment bits carry no information.
  logic unused_if_addr;
  assign unused_if_addr = ^if_addr[1:0];

  // Data has priority unless fetch has been passed over STARVE_LIMIT times.
  assign grant_d  = d_req && !((starve_q == STARVE_MAX) && if_req);
  assign grant_if = !grant_d && if_req;
  assign d_bad    = access_bad(d_size, d_addr[1:0]);

  mem_lane_unit u_lane (
    .wr_size_i    (d_size),
    .wr_addr_lo_i (d_addr[1:0]),
    .wr_data_i    (d_wdata),
    .be_o         (wr_be),
    .wr_data_o    (wr_rep),
    .rd_size_i    (size_q),
    .rd_addr_lo_i (addr_lo_q),
    .rd_signed_i  (signed_q),
    .rd_data_i    (mem_rdata),
    .rd_data_o    (rd_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      to_cnt_q    <= '0;
      size_q      <= SZ_WORD;
      addr_lo_q   <= '0;
      signed_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;

      case (state_q)
        ST_IDLE: begin
          to_cnt_q <= '0;
          if (grant_d) begin
            if (if_req) starve_q <= starve_q + 4'd1;
            if (d_bad) begin
              // Rejected before reaching the bus.
              state_q <= ST_RESP;
              d_ack_q <= 1'b1;
              d_err_q <= 1'b1;
            end else begin
              state_q     <= ST_BUSY_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= d_we;
              mem_addr_q  <= {d_addr[31:2], 2'b00};
              mem_be_q    <= wr_be;
              mem_wdata_q <= wr_rep;
              size_q      <= d_size;
              addr_lo_q   <= d_addr[1:0];
              signed_q    <= d_signed;
            end
          end else if (grant_if) begin
            starve_q    <= '0;
            state_q     <= ST_BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {if_addr[31:2], 2'b00};
            mem_be_q    <= 4'b1111;
            mem_wdata_q <= '0;
            size_q      <= SZ_WORD;
            addr_lo_q   <= 2'b00;
            signed_q    <= 1'b0;
          end
        end

        ST_BUSY_IF, ST_BUSY_D: begin
          // mem_ack takes precedence over a timeout in the same cycle.
          if (mem_ack || (to_cnt_q == TO_LAST)) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if (state_q == ST_BUSY_IF) begin
              if_ack_q   <= 1'b1;
              if_err_q   <= !mem_ack;
              if_rdata_q <= mem_ack ? rd_ext : 32'd0;
            end else begin
              d_ack_q   <= 1'b1;
              d_err_q   <= !mem_ack;
              d_rdata_q <= (mem_ack && !mem_we_q) ? rd_ext : 32'd0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
        end

        ST_RESP: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req, d_we, d_signed;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Everything is driven and sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_data(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata);
    d_req    = 1'b1;
    d_we     = we;
    d_size   = size;
    d_signed = sgn;
    d_addr   = addr;
    d_wdata  = wdata;
  endtask

  // Memory responder: waits (bounded) for mem_req, snapshots the bus fields,
  // holds off for 'waits' cycles, then pulses mem_ack with 'rd'. On return
  // the requester ack is visible.
  task automatic serve(input int waits, input logic [31:0] rd, output logic seen,
                       output logic [31:0] addr, output logic [3:0] be,
                       output logic [31:0] wdata, output logic we);
    seen = 1'b0;
    addr = '0; be = '0; wdata = '0; we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (seen) begin
      addr = mem_addr; be = mem_be; wdata = mem_wdata; we = mem_we;
      for (int i = 0; i < waits; i++) step();
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  endtask

  logic        seen, we_s;
  logic [31:0] addr_s, wd_s;
  logic [3:0]  be_s;
  int          cnt;
  logic        any_ack;
  logic [31:0] grant_exp[6] = '{32'h600, 32'h600, 32'h600, 32'h600, 32'h500, 32'h600};

  initial begin
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_size = 2'b11;
    d_signed = 0; d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    step(); step();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    step();

    // mem_ack in IDLE has no effect
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    check("idle_ack_ignored", {30'd0, if_ack, d_ack}, 32'd0);

    // 1: lone fetch, 3 wait cycles
    if_req = 1'b1; if_addr = 32'h100;
    serve(3, 32'hE3A01005, seen, addr_s, be_s, wd_s, we_s);
    if_req = 1'b0;
    check("f_req_seen", {31'd0, seen}, 32'd1);
    check("f_addr", addr_s, 32'h100);
    check("f_be", {28'd0, be_s}, 32'hF);
    check("f_ack", {31'd0, if_ack}, 32'd1);
    check("f_rdata", if_rdata, 32'hE3A01005);
    check("f_err", {31'd0, if_err}, 32'd0);
    check("f_mem_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    check("f_ack_pulse", {31'd0, if_ack}, 32'd0);

    // 2: signed then unsigned byte load from lane 3
    drive_data(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
    serve(1, 32'h80FF1234, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("sb_be", {28'd0, be_s}, 32'h8);
    check("sb_addr", addr_s, 32'h200);
    check("sb_rdata", d_rdata, 32'hFFFFFF80);
    check("sb_ack", {31'd0, d_ack}, 32'd1);
    step();
    drive_data(1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    serve(0, 32'h80FF1234, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("ub_rdata", d_rdata, 32'h00000080);
    step();

    // signed halfword, low lane; word load passes through
    drive_data(1'b0, 2'b01, 1'b1, 32'h400, 32'h0);
    serve(0, 32'h12348001, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("sh_be", {28'd0, be_s}, 32'h3);
    check("sh_rdata", d_rdata, 32'hFFFF8001);
    step();
    drive_data(1'b0, 2'b11, 1'b1, 32'h404, 32'h0);
    serve(2, 32'h89ABCDEF, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("w_rdata", d_rdata, 32'h89ABCDEF);
    step();

    // 3: halfword store to upper lane
    drive_data(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000BEEF);
    serve(1, 32'hDEADBEEF, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("hs_be", {28'd0, be_s}, 32'hC);
    check("hs_wdata", wd_s, 32'hBEEFBEEF);
    check("hs_addr", addr_s, 32'h300);
    check("hs_we", {31'd0, we_s}, 32'd1);
    check("hs_rdata", d_rdata, 32'd0);
    check("hs_ack", {31'd0, d_ack}, 32'd1);
    step();

    // byte store lane 1
    drive_data(1'b1, 2'b00, 1'b0, 32'h305, 32'h000000A5);
    serve(0, 32'h0, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("bs_be", {28'd0, be_s}, 32'h2);
    check("bs_wdata", wd_s, 32'hA5A5A5A5);
    step();

    // 5: misaligned / illegal accesses: immediate error, no bus cycle
    drive_data(1'b0, 2'b11, 1'b0, 32'h401, 32'h0);
    step();
    d_req = 1'b0;
    check("mis_w_ack", {31'd0, d_ack}, 32'd1);
    check("mis_w_err", {31'd0, d_err}, 32'd1);
    check("mis_w_rdata", d_rdata, 32'd0);
    check("mis_w_memreq", {31'd0, mem_req}, 32'd0);
    step();
    check("mis_w_memreq2", {31'd0, mem_req}, 32'd0);
    drive_data(1'b0, 2'b01, 1'b0, 32'h403, 32'h0);
    step();
    d_req = 1'b0;
    check("mis_h_err", {31'd0, d_err}, 32'd1);
    step();
    drive_data(1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
    step();
    d_req = 1'b0;
    check("ill_sz_err", {31'd0, d_err}, 32'd1);
    check("ill_sz_memreq", {31'd0, mem_req}, 32'd0);
    step();

    // 4: both requesters held high: D,D,D,D,IF,D
    if_req = 1'b1; if_addr = 32'h500;
    drive_data(1'b0, 2'b11, 1'b0, 32'h600, 32'h0);
    for (int k = 0; k < 6; k++) begin
      serve(0, 32'h0, seen, addr_s, be_s, wd_s, we_s);
      check($sformatf("grant_%0d", k), addr_s, grant_exp[k]);
      check($sformatf("ack_kind_%0d", k), {30'd0, if_ack, d_ack},
            (grant_exp[k] == 32'h500) ? 32'd2 : 32'd1);
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // 6: timeout after exactly 8 cycles of mem_req
    drive_data(1'b0, 2'b11, 1'b0, 32'h700, 32'h0);
    for (int i = 0; i < 10 && !mem_req; i++) step();
    cnt = 0;
    while (mem_req && cnt < 50) begin
      cnt++;
      step();
    end
    d_req = 1'b0;
    check("to_cycles", cnt, 32'd8);
    check("to_ack", {31'd0, d_ack}, 32'd1);
    check("to_err", {31'd0, d_err}, 32'd1);
    check("to_rdata", d_rdata, 32'd0);
    step();

    // mem_ack on the last allowed cycle wins over the timeout
    drive_data(1'b0, 2'b11, 1'b0, 32'h704, 32'h0);
    serve(7, 32'hCAFEF00D, seen, addr_s, be_s, wd_s, we_s);
    d_req = 1'b0;
    check("to_edge_ack", {31'd0, d_ack}, 32'd1);
    check("to_edge_err", {31'd0, d_err}, 32'd0);
    check("to_edge_rdata", d_rdata, 32'hCAFEF00D);
    step();

    // reset during BUSY_D: outputs clear, no ack for the aborted access
    drive_data(1'b0, 2'b11, 1'b0, 32'h800, 32'h0);
    step();
    step();
    check("rb_busy", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0; d_req = 1'b0;
    check("rb_mem_req", {31'd0, mem_req}, 32'd0);
    check("rb_mem_addr", mem_addr, 32'd0);
    check("rb_mem_be", {28'd0, mem_be}, 32'd0);
    check("rb_state", {30'd0, dbg_state}, 32'd0);
    any_ack = d_ack | if_ack;
    for (int i = 0; i < 5; i++) begin
      step();
      any_ack = any_ack | d_ack | if_ack;
    end
    check("rb_no_ack", {31'd0, any_ack}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
